// File: rtl/dm_arbiter_pkg.sv
// Shared defaults for the data-memory arbiter and data_mem: widths and requester limits.
// Also holds the requester-index width helper used by the arbiter and its picker.
package dm_arbiter_pkg;

  localparam int DM_DWIDTH   = 32;
  localparam int DM_AWIDTH   = 5;
  localparam int DM_NREQ_MIN = 2;
  localparam int DM_NREQ_MAX = 8;

  // Index width for n requesters; never below one bit.
  function automatic int dm_idw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dm_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after last+1, modulo NREQ.
// Zero latency; no state.
module rr_pick
  import dm_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = dm_idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int         cand;
  logic [IDW-1:0] cidx;
  logic       found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      cidx = IDW'(cand);
      if (!found && req[cidx]) begin
        found     = 1'b1;
        gnt[cidx] = 1'b1;
        idx       = cidx;
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin owner of the single-port data memory: one access per cycle, reads
// answered one cycle later on the issuing requester's rsp_valid bit.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int DWIDTH = DM_DWIDTH,
  parameter int AWIDTH = DM_AWIDTH,
  parameter int NREQ   = 2,
  parameter int IDW    = dm_idw(NREQ)
) (
  input  logic                   arb_clk,
  input  logic                   arb_rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*AWIDTH-1:0] req_addr,
  input  logic [NREQ*DWIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]        req_gnt,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]      rsp_rdata,
  output logic                   mem_we,
  output logic                   mem_re,
  output logic [AWIDTH-1:0]      mem_addr,
  output logic [DWIDTH-1:0]      mem_wdata,
  input  logic [DWIDTH-1:0]      mem_rdata
);

  logic [IDW-1:0]    last;
  logic              pend;
  logic [IDW-1:0]    pend_id;

  logic [NREQ-1:0]   pick_gnt;
  logic [IDW-1:0]    pick_idx;
  logic              pick_any;
  logic              xfer;

  logic [AWIDTH-1:0] addr_arr  [NREQ];
  logic [DWIDTH-1:0] wdata_arr [NREQ];

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req  (req_valid),
    .last (last),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i]  = req_addr[i*AWIDTH +: AWIDTH];
      wdata_arr[i] = req_wdata[i*DWIDTH +: DWIDTH];
    end
  end

  // Reset suppresses the grant so no transfer can land while it is held.
  assign xfer    = pick_any & arb_rst;
  assign req_gnt = xfer ? pick_gnt : '0;

  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (xfer) begin
      mem_we    = req_we[pick_idx];
      mem_re    = ~req_we[pick_idx];
      mem_addr  = addr_arr[pick_idx];
      mem_wdata = wdata_arr[pick_idx];
    end
  end

  always_ff @(posedge arb_clk or negedge arb_rst) begin
    if (!arb_rst) begin
      last    <= IDW'(NREQ - 1);
      pend    <= 1'b0;
      pend_id <= '0;
    end else begin
      if (xfer) begin
        last <= pick_idx;
      end
      pend <= xfer & ~req_we[pick_idx];
      if (xfer && !req_we[pick_idx]) begin
        pend_id <= pick_idx;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (pend) begin
      rsp_valid[pend_id] = 1'b1;
      rsp_rdata          = mem_rdata;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter (NREQ=4) with a one-cycle-latency memory model and a
// response scoreboard drained by an independent monitor.
module tb_dm_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 4;

  logic            arb_clk = 1'b0;
  logic            arb_rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_gnt;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_we;
  logic            mem_re;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;

  always #5 arb_clk = ~arb_clk;

  dm_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .NREQ(N)) dut (
    .arb_clk   (arb_clk),
    .arb_rst   (arb_rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_gnt   (req_gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory model: write at the handshake edge, read data registered one cycle later.
  logic [DW-1:0] mem [32];
  logic          preload = 1'b0;

  always @(posedge arb_clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE_0000 | DW'(i);
      mem[3]    <= 32'h11;
      mem[7]    <= 32'h22;
      mem_rdata <= '0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  always @(posedge arb_clk) cyc <= cyc + 1;

  always @(negedge arb_clk) begin : monitor
    logic [N-1:0]  ev;
    logic [DW-1:0] ed;
    if (mon_en) begin
      ev = '0;
      ed = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        ev[sb[0].id] = 1'b1;
        ed = sb[0].data;
        sb.delete(0);
      end
      checks++;
      if (rsp_valid !== ev || rsp_rdata !== ed) begin
        errors++;
        $display("FAIL rsp cyc=%0d got valid=%b data=%h want valid=%b data=%h",
                 cyc, rsp_valid, rsp_rdata, ev, ed);
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clr();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic chk(input string name, input logic [N-1:0] eg, input logic ewe,
                     input logic ere, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    #3;
    checks++;
    if ({req_gnt, mem_we, mem_re, mem_addr, mem_wdata} !== {eg, ewe, ere, ea, ed}) begin
      errors++;
      $display("FAIL %s got gnt=%b we=%b re=%b addr=%0d wdata=%h want gnt=%b we=%b re=%b addr=%0d wdata=%h",
               name, req_gnt, mem_we, mem_re, mem_addr, mem_wdata, eg, ewe, ere, ea, ed);
    end
  endtask

  task automatic nxt();
    @(posedge arb_clk);
    #1;
  endtask

  task automatic exp_rd(input int id, input logic [31:0] d);
    exp_t e;
    e.due  = cyc + 1;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  initial begin
    #2 arb_rst = 1'b0;
    preload = 1'b1;
    set_req(0, 1'b1, 1'b0, 5'd0, 32'h0);
    nxt();
    chk("rst_hold", 4'b0000, 1'b0, 1'b0, 5'd0, 32'h0);
    nxt();
    preload = 1'b0;
    mon_en  = 1'b1;
    clr();

    // Release: requester 0 has first priority
    arb_rst = 1'b1;
    set_req(0, 1'b1, 1'b1, 5'd1, 32'hA);
    set_req(1, 1'b1, 1'b1, 5'd2, 32'hB);
    chk("prio0", 4'b0001, 1'b1, 1'b0, 5'd1, 32'hA);
    nxt();
    set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("prio1", 4'b0010, 1'b1, 1'b0, 5'd2, 32'hB);
    nxt();
    clr();

    // Write then read of the same address
    set_req(0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    chk("wr5", 4'b0001, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
    nxt();
    set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 1'b0, 5'd5, 32'h0);
    chk("rd5", 4'b0010, 1'b0, 1'b1, 5'd5, 32'h0);
    exp_rd(1, 32'hDEADBEEF);
    nxt();
    clr();
    chk("idle_a", 4'b0000, 1'b0, 1'b0, 5'd0, 32'h0);
    nxt();

    // Back-to-back reads from different requesters
    set_req(0, 1'b1, 1'b0, 5'd3, 32'h0);
    chk("b2b0", 4'b0001, 1'b0, 1'b1, 5'd3, 32'h0);
    exp_rd(0, 32'h11);
    nxt();
    set_req(0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 1'b0, 5'd7, 32'h0);
    chk("b2b1", 4'b0010, 1'b0, 1'b1, 5'd7, 32'h0);
    exp_rd(1, 32'h22);
    nxt();
    clr();
    chk("idle_b", 4'b0000, 1'b0, 1'b0, 5'd0, 32'h0);
    nxt();

    // Park last on requester 3, then rotate with everyone requesting
    set_req(3, 1'b1, 1'b1, 5'd11, 32'h33);
    chk("lone3", 4'b1000, 1'b1, 1'b0, 5'd11, 32'h33);
    nxt();
    clr();
    for (int i = 0; i < N; i++)
      set_req(i, 1'b1, i[0], AW'(8 + i), i[0] ? 32'h100 + i : 32'h0);
    for (int k = 0; k < 8; k++) begin
      int w;
      w = k % N;
      chk($sformatf("rr%0d", k), N'(1 << w), w[0], ~w[0], AW'(8 + w),
          w[0] ? 32'h100 + w : 32'h0);
      if (!w[0]) exp_rd(w, 32'hC0DE_0000 | (8 + w));
      nxt();
    end
    clr();

    // Lone requester 1 granted every cycle
    set_req(1, 1'b1, 1'b0, 5'd5, 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("lone1_%0d", k), 4'b0010, 1'b0, 1'b1, 5'd5, 32'h0);
      exp_rd(1, 32'hDEADBEEF);
      nxt();
    end
    clr();
    chk("idle_c", 4'b0000, 1'b0, 1'b0, 5'd0, 32'h0);
    nxt();

    // Reset lands between a read grant and its response edge
    set_req(0, 1'b1, 1'b0, 5'd3, 32'h0);
    chk("mid_gnt", 4'b0001, 1'b0, 1'b1, 5'd3, 32'h0);
    arb_rst = 1'b0;
    chk("rst_force", 4'b0000, 1'b0, 1'b0, 5'd0, 32'h0);
    nxt();
    arb_rst = 1'b1;
    set_req(3, 1'b1, 1'b0, 5'd8, 32'h0);
    chk("post_rst", 4'b0001, 1'b0, 1'b1, 5'd3, 32'h0);
    exp_rd(0, 32'h11);
    nxt();
    clr();
    chk("idle_d", 4'b0000, 1'b0, 1'b0, 5'd0, 32'h0);
    nxt();
    nxt();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending responses want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
